// File: rtl/rng_wb_fetch_master_if.sv
// Wishbone classic bus bundle between the RNG fetch master and the RNG/AES slave.
// Pure wiring: no logic and no added latency.
// Backpressure is carried by the slave holding wbm_ack_i low.
interface rng_wb_fetch_master_if;
   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic        wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o;
   logic [31:0] wbm_dat_o;
   logic [31:0] wbm_dat_i;
   logic        wbm_ack_i;

   modport master (
      output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
      input  wbm_dat_i, wbm_ack_i
   );

   modport slave (
      input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
      output wbm_dat_i, wbm_ack_i
   );
endinterface

// File: rtl/rng_wb_fetch_master.sv
// Wishbone master that triggers the RNG, then reads X/Y/Z per sample into an output FWFT FIFO.
// Bus outputs are registered, so a cycle begins one clock after its decision; FIFO data is visible the cycle after the read ack.
// A read starts only when the FIFO has a free slot; a stalled m_ready parks the FSM in WAITSP with cyc low.
// Optional ack timeout with abort is enabled by defining RNG_WBM_TIMEOUT_EN.
module rng_wb_fetch_master #(
   parameter logic [31:0] BASE_ADR   = 32'h3000_0000,
   parameter int          FIFO_DEPTH = 8,
   parameter int          TIMEOUT    = 16
) (
   input  logic                  wb_clk_i,
   input  logic                  rst,
   input  logic                  start,
   input  logic [7:0]            burst_len,
   rng_wb_fetch_master_if.master wb,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [31:0]           m_data,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);
   localparam int          AW       = $clog2(FIFO_DEPTH);
   localparam int          CW       = AW + 1;
   localparam logic [31:0] ADR_TRIG = BASE_ADR + 32'h818;
   localparam logic [31:0] ADR_X    = BASE_ADR + 32'h81C;

   // Reject depths the pointer arithmetic cannot handle and a zero timeout.
   generate
      if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
         $error("rng_wb_fetch_master: FIFO_DEPTH must be a power of 2 >= 4 and TIMEOUT >= 1");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE, S_TRIG, S_GAP, S_WAITSP, S_RD, S_ABORT
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [1:0]  rd_idx_q, rd_idx_d;
   logic        last_q, last_d;
   logic        cyc_q, cyc_d;
   logic        we_q, we_d;
   logic [3:0]  sel_q, sel_d;
   logic [31:0] adr_q, adr_d;
   logic [31:0] dat_q, dat_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic [31:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] fcnt_q, fcnt_d;

   logic ack;
   logic push;
   logic pop;
   logic fifo_free;
   logic tmo_hit;

   // An ack only counts while our own cycle is open; the slave's repeated ack lands in GAP.
   assign ack       = cyc_q & wb.wbm_ack_i;
   assign push      = (state_q == S_RD) & ack;
   assign pop       = m_valid & m_ready;
   assign fifo_free = (fcnt_q != CW'(FIFO_DEPTH));

`ifdef RNG_WBM_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] tmo_q, tmo_d;
   logic          err_q, err_d;

   // Cycles spent with cyc high; restarts whenever the bus goes idle.
   always_comb begin
      tmo_d = cyc_q ? tmo_q + TW'(1) : '0;
   end

   assign tmo_hit = cyc_q & ~wb.wbm_ack_i & (tmo_q == TW'(TIMEOUT - 1));
   assign err     = err_q;

   // Timeout counter and sticky error flag.
   always_ff @(posedge wb_clk_i) begin
      if (rst) begin
         tmo_q <= '0;
         err_q <= 1'b0;
      end else begin
         tmo_q <= tmo_d;
         err_q <= err_d;
      end
   end
`else
   assign tmo_hit = 1'b0;
   assign err     = 1'b0;
`endif

   // Next-state and next-output decisions for the fetch sequence.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rd_idx_d = rd_idx_q;
      last_d   = last_q;
      cyc_d    = cyc_q;
      we_d     = we_q;
      sel_d    = sel_q;
      adr_d    = adr_q;
      dat_d    = dat_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
`ifdef RNG_WBM_TIMEOUT_EN
      err_d    = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (burst_len != 8'd0) begin
                  cnt_d   = burst_len;
                  busy_d  = 1'b1;
                  state_d = S_TRIG;
                  cyc_d   = 1'b1;
                  we_d    = 1'b1;
                  sel_d   = 4'hF;
                  adr_d   = ADR_TRIG;
                  dat_d   = 32'h1;
`ifdef RNG_WBM_TIMEOUT_EN
                  err_d   = 1'b0;
`endif
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         S_TRIG, S_RD: begin
            if (tmo_hit || ack) begin
               cyc_d = 1'b0;
               we_d  = 1'b0;
               sel_d = 4'h0;
               adr_d = 32'h0;
               dat_d = 32'h0;
            end
            if (tmo_hit) begin
               state_d = S_ABORT;
               busy_d  = 1'b0;
               done_d  = 1'b1;
`ifdef RNG_WBM_TIMEOUT_EN
               err_d   = 1'b1;
`endif
            end else if (ack) begin
               state_d = S_GAP;
               if (state_q == S_TRIG) begin
                  rd_idx_d = 2'd0;
                  last_d   = 1'b0;
               end else begin
                  last_d   = (rd_idx_q == 2'd2);
                  rd_idx_d = (rd_idx_q == 2'd2) ? 2'd0 : rd_idx_q + 2'd1;
               end
            end
         end
         S_GAP: begin
            if (last_q) begin
               last_d = 1'b0;
               cnt_d  = cnt_q - 8'd1;
               if (cnt_q == 8'd1) begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_TRIG;
                  cyc_d   = 1'b1;
                  we_d    = 1'b1;
                  sel_d   = 4'hF;
                  adr_d   = ADR_TRIG;
                  dat_d   = 32'h1;
               end
            end else begin
               state_d = S_WAITSP;
            end
         end
         S_WAITSP: begin
            if (fifo_free) begin
               state_d = S_RD;
               cyc_d   = 1'b1;
               we_d    = 1'b0;
               sel_d   = 4'hF;
               adr_d   = ADR_X + {28'd0, rd_idx_q, 2'b00};
               dat_d   = 32'h0;
            end
         end
         S_ABORT: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // FSM state and registered bus/status outputs.
   always_ff @(posedge wb_clk_i) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= 8'd0;
         rd_idx_q <= 2'd0;
         last_q   <= 1'b0;
         cyc_q    <= 1'b0;
         we_q     <= 1'b0;
         sel_q    <= 4'h0;
         adr_q    <= 32'h0;
         dat_q    <= 32'h0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rd_idx_q <= rd_idx_d;
         last_q   <= last_d;
         cyc_q    <= cyc_d;
         we_q     <= we_d;
         sel_q    <= sel_d;
         adr_q    <= adr_d;
         dat_q    <= dat_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   // FIFO pointer/occupancy update; pointers wrap naturally at the power-of-2 depth.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      fcnt_d = fcnt_q + CW'(push) - CW'(pop);
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge wb_clk_i) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fcnt_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fcnt_q   <= fcnt_d;
      end
   end

   // FIFO storage; contents are only meaningful between the pointers, so no reset.
   always_ff @(posedge wb_clk_i) begin
      if (push) mem_q[wr_ptr_q] <= wb.wbm_dat_i;
   end

   assign m_valid      = (fcnt_q != '0);
   assign m_data       = mem_q[rd_ptr_q];
   assign busy         = busy_q;
   assign done         = done_q;
   assign wb.wbm_cyc_o = cyc_q;
   assign wb.wbm_stb_o = cyc_q;
   assign wb.wbm_we_o  = we_q;
   assign wb.wbm_sel_o = sel_q;
   assign wb.wbm_adr_o = adr_q;
   assign wb.wbm_dat_o = dat_q;
endmodule

// File: tb/tb_rng_wb_fetch_master.sv
// Bench for rng_wb_fetch_master: directed burst table plus hand sequences for corner cases.
// Slave model acks one cycle after strobe, optionally holds ack one extra cycle or stalls.
// Read data encodes a running read index and the address, so order and addressing are both checked.
module tb_rng_wb_fetch_master;
   localparam logic [31:0] BASE = 32'h3000_0000;

   logic        wb_clk_i = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  burst_len;
   logic        m_ready;
   logic        m_valid;
   logic [31:0] m_data;
   logic        busy;
   logic        done;
   logic        err;

   rng_wb_fetch_master_if wb_if ();

   rng_wb_fetch_master #(
      .BASE_ADR  (BASE),
      .FIFO_DEPTH(8),
      .TIMEOUT   (16)
   ) u_dut (
      .wb_clk_i (wb_clk_i),
      .rst      (rst),
      .start    (start),
      .burst_len(burst_len),
      .wb       (wb_if),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_data   (m_data),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   int chk_n  = 0;
   int fail_n = 0;

   // Slave model state.
   bit          hold_ack = 1'b0;
   int          stall_at = -1;
   int          acc_n    = 0;
   int          rd_seq   = 0;
   int          slv_viol = 0;
   logic [32:0] bus_log [512];

   always @(posedge wb_clk_i) begin
      if (rst) begin
         wb_if.wbm_ack_i <= 1'b0;
         wb_if.wbm_dat_i <= 32'h0;
      end else if (wb_if.wbm_cyc_o && wb_if.wbm_stb_o && !wb_if.wbm_ack_i &&
                   (stall_at < 0 || acc_n < stall_at)) begin
         wb_if.wbm_ack_i <= 1'b1;
         bus_log[acc_n[8:0]] <= {wb_if.wbm_we_o, wb_if.wbm_adr_o};
         acc_n <= acc_n + 1;
         if (wb_if.wbm_sel_o != 4'hF || (wb_if.wbm_we_o && wb_if.wbm_dat_o != 32'h1))
            slv_viol <= slv_viol + 1;
         if (!wb_if.wbm_we_o) begin
            wb_if.wbm_dat_i <= {8'hD0, rd_seq[11:0], wb_if.wbm_adr_o[11:0]};
            rd_seq <= rd_seq + 1;
         end
      end else if (hold_ack) begin
         wb_if.wbm_ack_i <= wb_if.wbm_cyc_o & wb_if.wbm_stb_o;
      end else begin
         wb_if.wbm_ack_i <= 1'b0;
      end
   end

   // Stream capture.
   logic [31:0] rx_mem [512];
   int          rx_n = 0;

   always @(posedge wb_clk_i) begin
      if (!rst && m_valid && m_ready) begin
         rx_mem[rx_n[8:0]] <= m_data;
         rx_n <= rx_n + 1;
      end
   end

   // Bus-protocol monitor: idle bus is all zero, GAP follows every ack, run length of cyc.
   int done_n   = 0;
   int mon_viol = 0;
   int run      = 0;
   int last_run = 0;
   bit prev_ack = 1'b0;

   always @(negedge wb_clk_i) begin
      if (done === 1'b1) done_n = done_n + 1;
      if (wb_if.wbm_cyc_o === 1'b0 &&
          (wb_if.wbm_stb_o || wb_if.wbm_we_o || wb_if.wbm_sel_o != 4'h0 ||
           wb_if.wbm_adr_o != 32'h0 || wb_if.wbm_dat_o != 32'h0))
         mon_viol = mon_viol + 1;
      if (prev_ack && wb_if.wbm_cyc_o === 1'b1) mon_viol = mon_viol + 1;
      prev_ack = (wb_if.wbm_cyc_o === 1'b1) && (wb_if.wbm_ack_i === 1'b1);
      if (wb_if.wbm_cyc_o === 1'b1) begin
         run = run + 1;
      end else begin
         if (run != 0) last_run = run;
         run = 0;
      end
   end

   typedef struct {
      logic [7:0] len;
      bit         hold;
      int         exp_words;
      int         exp_xfers;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_n = chk_n + 1;
      if (act !== exp) begin
         fail_n = fail_n + 1;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic pulse_start(input logic [7:0] len);
      @(negedge wb_clk_i);
      start     = 1'b1;
      burst_len = len;
      @(negedge wb_clk_i);
      start     = 1'b0;
   endtask

   task automatic wait_done(input int base, input int budget);
      for (int i = 0; i < budget && done_n == base; i++) @(negedge wb_clk_i);
      @(negedge wb_clk_i);
   endtask

   task automatic check_words(input int base_rx, input int base_seq, input int n);
      logic [31:0] exp;
      int          idx;
      for (int i = 0; i < n; i++) begin
         idx = base_rx + i;
         exp = {8'hD0, 12'(base_seq + i), 12'(32'h81C + 4 * (i % 3))};
         chk($sformatf("word%0d", i), rx_mem[idx[8:0]], exp);
      end
   endtask

   task automatic check_bus(input int base_acc, input int n);
      int          bad;
      int          idx;
      logic [32:0] eb;
      bad = 0;
      for (int k = 0; k < n; k++) begin
         idx = base_acc + k;
         if (k % 4 == 0) eb = {1'b1, BASE + 32'h818};
         else            eb = {1'b0, BASE + 32'h81C + 32'(4 * (k % 4 - 1))};
         if (bus_log[idx[8:0]] !== eb) bad = bad + 1;
      end
      chk("bus_order", 32'(bad), 32'h0);
   endtask

   task automatic run_vec(input vec_t r);
      int b_done, b_rx, b_acc, b_seq, b_viol;
      b_done = done_n; b_rx = rx_n; b_acc = acc_n; b_seq = rd_seq;
      b_viol = mon_viol + slv_viol;
      hold_ack = r.hold;
      m_ready  = 1'b1;
      pulse_start(r.len);
      wait_done(b_done, 2000);
      repeat (20) @(negedge wb_clk_i);
      chk("done_count", 32'(done_n - b_done), 32'd1);
      chk("word_count", 32'(rx_n - b_rx), 32'(r.exp_words));
      chk("xfer_count", 32'(acc_n - b_acc), 32'(r.exp_xfers));
      check_words(b_rx, b_seq, r.exp_words);
      check_bus(b_acc, r.exp_xfers);
      chk("protocol", 32'(mon_viol + slv_viol - b_viol), 32'h0);
      chk("busy_end", 32'(busy), 32'h0);
      chk("err_end", 32'(err), 32'h0);
      hold_ack = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int b_done, b_rx, b_acc, b_seq;
      bit found;

      rst = 1'b1; start = 1'b0; burst_len = 8'd0; m_ready = 1'b0;
      vecs[0] = '{len: 8'd1, hold: 1'b0, exp_words: 3, exp_xfers: 4};
      vecs[1] = '{len: 8'd2, hold: 1'b0, exp_words: 6, exp_xfers: 8};
      vecs[2] = '{len: 8'd3, hold: 1'b1, exp_words: 9, exp_xfers: 12};
      vecs[3] = '{len: 8'd2, hold: 1'b1, exp_words: 6, exp_xfers: 8};
      vecs[4] = '{len: 8'd0, hold: 1'b0, exp_words: 0, exp_xfers: 0};

      // Reset values.
      repeat (3) @(negedge wb_clk_i);
      chk("rst_cyc", 32'(wb_if.wbm_cyc_o), 32'h0);
      chk("rst_stb", 32'(wb_if.wbm_stb_o), 32'h0);
      chk("rst_we", 32'(wb_if.wbm_we_o), 32'h0);
      chk("rst_sel", 32'(wb_if.wbm_sel_o), 32'h0);
      chk("rst_adr", wb_if.wbm_adr_o, 32'h0);
      chk("rst_dat", wb_if.wbm_dat_o, 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      chk("rst_mvalid", 32'(m_valid), 32'h0);
      rst = 1'b0;
      @(negedge wb_clk_i);

      // Zero-length burst: done exactly one cycle after start, no bus activity.
      pulse_start(8'd0);
      chk("len0_done", 32'(done), 32'h1);
      chk("len0_cyc", 32'(wb_if.wbm_cyc_o), 32'h0);
      chk("len0_busy", 32'(busy), 32'h0);
      @(negedge wb_clk_i);
      chk("len0_done_drop", 32'(done), 32'h0);

      for (int v = 0; v < 5; v++) run_vec(vecs[v]);

      // Backpressure: a stalled consumer caps fetching at the FIFO depth.
      b_done = done_n; b_rx = rx_n; b_acc = acc_n; b_seq = rd_seq;
      m_ready = 1'b0;
      pulse_start(8'd4);
      repeat (150) @(negedge wb_clk_i);
      chk("bp_xfers_stalled", 32'(acc_n - b_acc), 32'd11);
      chk("bp_cyc_stalled", 32'(wb_if.wbm_cyc_o), 32'h0);
      chk("bp_busy_stalled", 32'(busy), 32'h1);
      chk("bp_mvalid", 32'(m_valid), 32'h1);
      chk("bp_head", m_data, {8'hD0, 12'(b_seq), 12'h81C});
      m_ready = 1'b1;
      wait_done(b_done, 2000);
      repeat (20) @(negedge wb_clk_i);
      chk("bp_words", 32'(rx_n - b_rx), 32'd12);
      chk("bp_xfers", 32'(acc_n - b_acc), 32'd16);
      check_words(b_rx, b_seq, 12);

      // Start while busy is ignored.
      b_done = done_n; b_rx = rx_n; b_acc = acc_n;
      pulse_start(8'd1);
      repeat (3) @(negedge wb_clk_i);
      pulse_start(8'd5);
      wait_done(b_done, 2000);
      repeat (40) @(negedge wb_clk_i);
      chk("busy_start_done", 32'(done_n - b_done), 32'd1);
      chk("busy_start_words", 32'(rx_n - b_rx), 32'd3);
      chk("busy_start_xfers", 32'(acc_n - b_acc), 32'd4);
      chk("busy_start_idle", 32'(busy), 32'h0);

      // Reset during the Y read discards the partial sample.
      m_ready = 1'b0;
      pulse_start(8'd2);
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge wb_clk_i);
         found = wb_if.wbm_cyc_o && !wb_if.wbm_we_o && (wb_if.wbm_adr_o == BASE + 32'h820);
      end
      chk("rstmid_reached_y", 32'(found), 32'h1);
      chk("rstmid_mvalid_before", 32'(m_valid), 32'h1);
      rst = 1'b1;
      @(negedge wb_clk_i);
      chk("rstmid_cyc", 32'(wb_if.wbm_cyc_o), 32'h0);
      chk("rstmid_mvalid", 32'(m_valid), 32'h0);
      chk("rstmid_busy", 32'(busy), 32'h0);
      rst = 1'b0;
      m_ready = 1'b1;
      repeat (2) @(negedge wb_clk_i);
      b_done = done_n; b_rx = rx_n; b_seq = rd_seq;
      pulse_start(8'd1);
      wait_done(b_done, 2000);
      repeat (20) @(negedge wb_clk_i);
      chk("rstmid_words", 32'(rx_n - b_rx), 32'd3);
      check_words(b_rx, b_seq, 3);

`ifdef RNG_WBM_TIMEOUT_EN
      // Missing ack on the trigger, then on the Z read: abort keeps already-fetched words.
      for (int s = 0; s < 2; s++) begin
         int offs;
         int keep;
         offs = (s == 0) ? 0 : 3;
         keep = (s == 0) ? 0 : 2;
         b_done = done_n; b_rx = rx_n; b_seq = rd_seq;
         m_ready  = 1'b0;
         stall_at = acc_n + offs;
         pulse_start(8'd1);
         wait_done(b_done, 400);
         chk("tmo_done", 32'(done_n - b_done), 32'd1);
         chk("tmo_cyc_len", 32'(last_run), 32'd16);
         chk("tmo_err", 32'(err), 32'h1);
         chk("tmo_busy", 32'(busy), 32'h0);
         chk("tmo_cyc", 32'(wb_if.wbm_cyc_o), 32'h0);
         chk("tmo_kept", 32'(m_valid), 32'(keep != 0));
         stall_at = -1;
         m_ready  = 1'b1;
         repeat (10) @(negedge wb_clk_i);
         chk("tmo_words", 32'(rx_n - b_rx), 32'(keep));
         check_words(b_rx, b_seq, keep);
      end
      run_vec(vecs[0]);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", chk_n, fail_n);
      $finish;
   end
endmodule
